// File: rtl/div_32.sv
// 32-bit signed restoring divider: fixed 32-step latency, one quotient bit per clock.
// Divide-by-zero and INT_MIN/-1 overflow are flagged through data_exception.
//
// state | meaning
// IDLE  | waiting for ctrl_DIV
// RUN   | 32 restoring-division steps, one per edge
// DONE  | result valid, data_resultRDY high for this cycle
module div_32 (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] quo, rem, b_mag;
  logic        sign, zero_div, ovf;
  logic [5:0]  count;

  logic        accept, last_step;
  logic [31:0] a_abs, b_abs, quo_nxt, rem_nxt, q_signed;
  logic [32:0] shifted, diff;

  assign accept    = ctrl_DIV && (state != RUN);
  assign last_step = (state == RUN) && (count == 6'd31);

  always_comb begin
    a_abs    = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    b_abs    = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
    // quo starts as |A|, so its MSB is always the next dividend bit to inject
    shifted  = {rem, quo[31]};
    diff     = shifted - {1'b0, b_mag};
    quo_nxt  = {quo[30:0], ~diff[32]};
    rem_nxt  = diff[32] ? shifted[31:0] : diff[31:0];
    q_signed = sign ? (~quo_nxt + 32'd1) : quo_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_DIV) state_nxt = RUN;
      RUN:     if (count == 6'd31) state_nxt = DONE;
      DONE:    state_nxt = ctrl_DIV ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      quo            <= 32'd0;
      rem            <= 32'd0;
      b_mag          <= 32'd0;
      sign           <= 1'b0;
      zero_div       <= 1'b0;
      ovf            <= 1'b0;
      count          <= 6'd0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
    end else if (accept) begin
      quo      <= a_abs;
      rem      <= 32'd0;
      b_mag    <= b_abs;
      sign     <= data_operandA[31] ^ data_operandB[31];
      zero_div <= (data_operandB == 32'd0);
      ovf      <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      count    <= 6'd0;
    end else if (state == RUN) begin
      quo   <= quo_nxt;
      rem   <= rem_nxt;
      count <= count + 6'd1;
      if (last_step) begin
        if (zero_div) begin
          data_result    <= 32'd0;
          data_exception <= 1'b1;
        end else if (ovf) begin
          data_result    <= 32'h8000_0000;
          data_exception <= 1'b1;
        end else begin
          data_result    <= q_signed;
          data_exception <= 1'b0;
        end
      end
    end
  end

  assign busy           = (state == RUN);
  assign data_resultRDY = (state == DONE);

endmodule
